display_scan_controller: RTL and testbench



---
 rtl/display_scan_controller_pkg.sv | 25 ++
 rtl/display_scan_controller_if.sv | 35 +++
 rtl/display_scan_controller_tick.sv | 26 ++
 rtl/display_scan_controller.sv | 148 ++++++++++++++
 tb/tb_display_scan_controller.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared state encoding and constants for the multiplexed display scanner.
// Defaults describe a 6-digit HH:MM:SS display on a 50 MHz clock.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_SCAN_HZ      = 1000;
    localparam int DEF_GUARD_CYCLES = 64;
    localparam int DEF_BLINK_HZ     = 2;
    localparam int DEF_NUM_DIGITS   = 6;

    localparam int DIGIT_HOUR_TENS = DEF_NUM_DIGITS - 1;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_ok(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Bundle between the timekeeping logic (master) and the scanner (slave).
// Carries the digit snapshot inputs and the decoder / digit-enable pins.
interface display_scan_controller_if #(
    parameter int NUM_DIGITS = display_pkg::DEF_NUM_DIGITS
);

    logic                      enable;
    logic [4*NUM_DIGITS-1:0]   digits_bcd;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic                      blank_leading;
    logic [3:0]                bcd_out;
    logic [NUM_DIGITS-1:0]     digit_en_n;
    logic                      frame_start;

    modport master (
        output enable,
        output digits_bcd,
        output blink_mask,
        output blank_leading,
        input  bcd_out,
        input  digit_en_n,
        input  frame_start
    );

    modport slave (
        input  enable,
        input  digits_bcd,
        input  blink_mask,
        input  blank_leading,
        output bcd_out,
        output digit_en_n,
        output frame_start
    );

endinterface

// File: rtl/display_scan_controller_tick.sv
// Modulus-MOD counter with a terminal-count flag; clr restarts at zero.
// Used for both the per-slot timer and the free-running blink timer.
module divide_tick #(
    parameter int MOD = 10,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tick
);

    assign tick = (cnt == W'(MOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS BCD digits onto one shared 7-segment decoder with
// a dark guard interval per slot, blinking, and zero/invalid blanking.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int SCAN_HZ      = DEF_SCAN_HZ,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int BLINK_HZ     = DEF_BLINK_HZ,
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS
) (
    input logic clk,
    input logic rst_n,
    display_scan_controller_if.slave bus
);

    localparam int DIGIT_CYCLES = CLK_HZ / SCAN_HZ;
    localparam int BLINK_HALF   = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int HOUR_TENS = DIGIT_HOUR_TENS + (NUM_DIGITS - DEF_NUM_DIGITS);

    scan_state_e             state;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] sh_bcd;
    logic [NUM_DIGITS-1:0]   sh_mask;
    logic                    blink_phase;

    logic [3:0]              bcd_q;
    logic [NUM_DIGITS-1:0]   en_n_q;
    logic                    fs_q;

    logic [SW-1:0]           slot_cnt;
    logic                    slot_end;
    logic                    slot_clr;
    logic [BW-1:0]           unused_blink_cnt;
    logic                    blink_end;

    logic [3:0]              sh_dig;
    logic [3:0]              new_dig;
    logic                    slot_first;
    logic                    last_idx;
    logic                    blink_off;
    logic                    lead_off;
    logic                    lit;

    assign slot_clr = (state == ST_IDLE) || !bus.enable;

    divide_tick #(
        .MOD (DIGIT_CYCLES),
        .W   (SW)
    ) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (slot_clr),
        .cnt   (slot_cnt),
        .tick  (slot_end)
    );

    divide_tick #(
        .MOD (BLINK_HALF),
        .W   (BW)
    ) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .cnt   (unused_blink_cnt),
        .tick  (blink_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_phase <= 1'b0;
        end else if (blink_end) begin
            blink_phase <= ~blink_phase;
        end
    end

    // Digit 0's slot start is also the snapshot point, so it reads the
    // live inputs rather than the shadow that is loaded on the same edge.
    assign sh_dig     = sh_bcd[idx*4 +: 4];
    assign new_dig    = (idx == '0) ? bus.digits_bcd[3:0] : sh_dig;
    assign slot_first = (state == ST_GUARD) && (slot_cnt == '0);
    assign last_idx   = (idx == IW'(NUM_DIGITS - 1));

    assign blink_off = sh_mask[idx] && blink_phase;
    assign lead_off  = bus.blank_leading
                    && (idx == IW'(HOUR_TENS))
                    && (sh_dig == 4'd0);
    assign lit       = bcd_ok(sh_dig) && !blink_off && !lead_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            sh_bcd  <= '0;
            sh_mask <= '0;
            bcd_q   <= '0;
            en_n_q  <= '1;
            fs_q    <= 1'b0;
        end else if (!bus.enable) begin
            state  <= ST_IDLE;
            idx    <= '0;
            bcd_q  <= '0;
            en_n_q <= '1;
            fs_q   <= 1'b0;
        end else begin
            en_n_q <= '1;
            fs_q   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    state <= ST_GUARD;
                    idx   <= '0;
                    bcd_q <= '0;
                end
                ST_GUARD: begin
                    if (slot_first) begin
                        bcd_q <= bcd_ok(new_dig) ? new_dig : 4'd0;
                        if (idx == '0) begin
                            sh_bcd  <= bus.digits_bcd;
                            sh_mask <= bus.blink_mask;
                            fs_q    <= 1'b1;
                        end
                    end
                    if (slot_cnt == SW'(GUARD_CYCLES - 1)) begin
                        state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    en_n_q <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
                    if (slot_end) begin
                        state <= ST_GUARD;
                        idx   <= last_idx ? '0 : idx + IW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.digit_en_n  = en_n_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomised and directed bench for display_scan_controller against a
// frame-position reference model (10-cycle slots, 60-cycle frames).
module tb_display_scan_controller;

    localparam int ND    = 6;
    localparam int DC    = 10;
    localparam int GC    = 2;
    localparam int BH    = 100;
    localparam int FRAME = ND * DC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    int n_edge = 0;
    int pos = -1;
    int cur_d = -1;
    int cur_w = -1;
    logic [23:0] snap = '0;
    logic [5:0]  msk = '0;
    logic [3:0]  exp_bcd = '0;
    logic [5:0]  exp_en = '1;
    logic        exp_fs = 1'b0;

    display_scan_controller_if #(.NUM_DIGITS(ND)) bus();

    display_scan_controller #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .GUARD_CYCLES (GC),
        .BLINK_HZ     (5),
        .NUM_DIGITS   (ND)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: pos counts cycles since the frame sequence began; the digit
    // and its position in the slot follow from plain division.
    task automatic step();
        int d;
        int w;
        int ph;
        logic [3:0] v;
        logic on;
        @(posedge clk);
        n_edge++;
        ph = ((n_edge - 1) / BH) % 2;
        if (!bus.enable || pos < 0) begin
            pos = bus.enable ? 0 : -1;
            exp_en = '1;
            exp_bcd = '0;
            exp_fs = 1'b0;
            cur_d = -1;
            cur_w = -1;
        end else begin
            w = pos % DC;
            d = (pos / DC) % ND;
            if (pos % FRAME == 0) begin
                snap = bus.digits_bcd;
                msk = bus.blink_mask;
            end
            v = snap[d*4 +: 4];
            on = (w >= GC) && (v <= 4'd9)
              && !(msk[d] && ph == 1)
              && !(bus.blank_leading && d == ND - 1 && v == 4'd0);
            exp_fs = (pos % FRAME == 0);
            exp_bcd = (v <= 4'd9) ? v : 4'd0;
            exp_en = on ? ~(6'b1 << d) : 6'h3f;
            cur_d = d;
            cur_w = w;
            pos++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.enable = 1'b0;
        bus.digits_bcd = '0;
        bus.blink_mask = '0;
        bus.blank_leading = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.digit_en_n, bus.bcd_out, bus.frame_start} !== {6'h3f, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got %b/%h/%b exp 111111/0/0",
                     bus.digit_en_n, bus.bcd_out, bus.frame_start);
        end
        rst_n = 1'b1;
        n_edge = 0;
        pos = -1;
        repeat (4) begin
            step();
            checks++;
            if ({bus.digit_en_n, bus.bcd_out, bus.frame_start} !== {exp_en, exp_bcd, exp_fs}) begin
                errors++;
                $display("FAIL idle edge %0d got %b/%h/%b exp %b/%h/%b", n_edge,
                         bus.digit_en_n, bus.bcd_out, bus.frame_start, exp_en, exp_bcd, exp_fs);
            end
        end
    endtask

    task automatic test_basic_scan();
        int last_fs = -1;
        bus.digits_bcd = 24'h123456;
        bus.enable = 1'b1;
        repeat (2 * FRAME + 5) begin
            step();
            checks++;
            if ({bus.digit_en_n, bus.bcd_out, bus.frame_start} !== {exp_en, exp_bcd, exp_fs}) begin
                errors++;
                $display("FAIL basic edge %0d got %b/%h/%b exp %b/%h/%b", n_edge,
                         bus.digit_en_n, bus.bcd_out, bus.frame_start, exp_en, exp_bcd, exp_fs);
            end
            if (bus.frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (n_edge - last_fs != FRAME) begin
                        errors++;
                        $display("FAIL frame_period got %0d exp %0d", n_edge - last_fs, FRAME);
                    end
                end
                last_fs = n_edge;
            end
        end
    endtask

    task automatic test_tearing();
        int k = 0;
        logic seen = 1'b0;
        while (!(cur_d == 2 && cur_w == 4) && k < 2 * FRAME) begin
            step();
            k++;
        end
        checks++;
        if (!(cur_d == 2 && cur_w == 4)) begin
            errors++;
            $display("FAIL tearing_align timeout got slot %0d exp 2", cur_d);
        end
        bus.digits_bcd = 24'h000000;
        repeat (2 * FRAME) begin
            step();
            checks++;
            if ({bus.digit_en_n, bus.bcd_out, bus.frame_start} !== {exp_en, exp_bcd, exp_fs}) begin
                errors++;
                $display("FAIL tearing edge %0d got %b/%h/%b exp %b/%h/%b", n_edge,
                         bus.digit_en_n, bus.bcd_out, bus.frame_start, exp_en, exp_bcd, exp_fs);
            end
            if (bus.frame_start) seen = 1'b1;
            if (!seen && cur_d >= 3) begin
                checks++;
                if (bus.bcd_out !== 4'(6 - cur_d)) begin
                    errors++;
                    $display("FAIL tearing_old digit %0d got %h exp %h", cur_d, bus.bcd_out, 4'(6 - cur_d));
                end
            end else if (seen) begin
                checks++;
                if (bus.bcd_out !== 4'h0) begin
                    errors++;
                    $display("FAIL tearing_new digit %0d got %h exp 0", cur_d, bus.bcd_out);
                end
            end
        end
    endtask

    task automatic test_blink();
        bus.digits_bcd = 24'h123456;
        bus.blink_mask = 6'b000011;
        repeat (450) begin
            step();
            checks++;
            if ({bus.digit_en_n, bus.bcd_out, bus.frame_start} !== {exp_en, exp_bcd, exp_fs}) begin
                errors++;
                $display("FAIL blink edge %0d got %b/%h/%b exp %b/%h/%b", n_edge,
                         bus.digit_en_n, bus.bcd_out, bus.frame_start, exp_en, exp_bcd, exp_fs);
            end
        end
    endtask

    task automatic test_leading_invalid();
        int low0;
        int low3;
        int low5;
        int k;
        bus.blink_mask = '0;
        bus.digits_bcd = 24'h09A959;
        for (int pass = 0; pass < 2; pass++) begin
            bus.blank_leading = (pass == 0);
            k = 0;
            while (pos % FRAME != 0 && k < 2 * FRAME) begin
                step();
                k++;
            end
            low0 = 0;
            low3 = 0;
            low5 = 0;
            repeat (FRAME) begin
                step();
                checks++;
                if ({bus.digit_en_n, bus.bcd_out, bus.frame_start} !== {exp_en, exp_bcd, exp_fs}) begin
                    errors++;
                    $display("FAIL lead%0d edge %0d got %b/%h/%b exp %b/%h/%b", pass, n_edge,
                             bus.digit_en_n, bus.bcd_out, bus.frame_start, exp_en, exp_bcd, exp_fs);
                end
                if (!bus.digit_en_n[0]) low0++;
                if (!bus.digit_en_n[3]) low3++;
                if (!bus.digit_en_n[5]) low5++;
                if (cur_d == 3 || cur_d == 5) begin
                    checks++;
                    if (bus.bcd_out !== 4'h0) begin
                        errors++;
                        $display("FAIL lead_bcd digit %0d got %h exp 0", cur_d, bus.bcd_out);
                    end
                end
            end
            checks++;
            if (low0 != DC - GC || low3 != 0 || low5 != (pass == 0 ? 0 : DC - GC)) begin
                errors++;
                $display("FAIL lead_counts pass %0d got %0d/%0d/%0d exp %0d/0/%0d",
                         pass, low0, low3, low5, DC - GC, pass == 0 ? 0 : DC - GC);
            end
        end
    endtask

    task automatic test_enable_drop();
        int k = 0;
        bus.digits_bcd = 24'h123456;
        bus.blank_leading = 1'b0;
        while (!(cur_d == 3 && cur_w == 5) && k < 2 * FRAME) begin
            step();
            k++;
        end
        checks++;
        if (bus.digit_en_n !== 6'b110111) begin
            errors++;
            $display("FAIL drop_pre got %b exp 110111", bus.digit_en_n);
        end
        bus.enable = 1'b0;
        step();
        checks++;
        if (bus.digit_en_n !== 6'h3f) begin
            errors++;
            $display("FAIL drop_dark got %b exp 111111", bus.digit_en_n);
        end
        repeat (3) step();
        bus.enable = 1'b1;
        step();
        step();
        checks++;
        if ({bus.frame_start, bus.bcd_out} !== {1'b1, 4'h6}) begin
            errors++;
            $display("FAIL reenable_frame got fs %b bcd %h exp fs 1 bcd 6", bus.frame_start, bus.bcd_out);
        end
        repeat (30) begin
            step();
            checks++;
            if ({bus.digit_en_n, bus.bcd_out, bus.frame_start} !== {exp_en, exp_bcd, exp_fs}) begin
                errors++;
                $display("FAIL reenable edge %0d got %b/%h/%b exp %b/%h/%b", n_edge,
                         bus.digit_en_n, bus.bcd_out, bus.frame_start, exp_en, exp_bcd, exp_fs);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        while (!(cur_d == 2 && cur_w == 5) && k < 2 * FRAME) begin
            step();
            k++;
        end
        checks++;
        if (bus.digit_en_n !== 6'b111011) begin
            errors++;
            $display("FAIL rstmid_pre got %b exp 111011", bus.digit_en_n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.digit_en_n, bus.bcd_out, bus.frame_start} !== {6'h3f, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_async got %b/%h/%b exp 111111/0/0",
                     bus.digit_en_n, bus.bcd_out, bus.frame_start);
        end
        #1 rst_n = 1'b1;
        n_edge = 0;
        pos = -1;
        repeat (FRAME + 10) begin
            step();
            checks++;
            if ({bus.digit_en_n, bus.bcd_out, bus.frame_start} !== {exp_en, exp_bcd, exp_fs}) begin
                errors++;
                $display("FAIL rstmid edge %0d got %b/%h/%b exp %b/%h/%b", n_edge,
                         bus.digit_en_n, bus.bcd_out, bus.frame_start, exp_en, exp_bcd, exp_fs);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] dg;
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int i = 0; i < ND; i++) dg[i*4 +: 4] = 4'($urandom_range(0, 11));
                bus.digits_bcd = dg;
            end
            if ($urandom_range(0, 29) == 0) bus.blink_mask = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 39) == 0) bus.blank_leading = ~bus.blank_leading;
            if ($urandom_range(0, 199) == 0) bus.enable = 1'b0;
            else if (!bus.enable && $urandom_range(0, 3) == 0) bus.enable = 1'b1;
            step();
            checks++;
            if ({bus.digit_en_n, bus.bcd_out, bus.frame_start} !== {exp_en, exp_bcd, exp_fs}) begin
                errors++;
                $display("FAIL random edge %0d got %b/%h/%b exp %b/%h/%b", n_edge,
                         bus.digit_en_n, bus.bcd_out, bus.frame_start, exp_en, exp_bcd, exp_fs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_tearing();
        test_blink();
        test_leading_invalid();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
